// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use / JR hazard detection and
// saturating stall/flush event counters.
module if_id_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instruction_if,
  input  logic [31:0]      PC,
  input  logic [31:0]      NextPC_if,
  input  logic             Flush,
  input  logic             MemRead_ex,
  input  logic             RegWrite_ex,
  input  logic [4:0]       WriteReg_ex,
  input  logic             MemRead_mem,
  input  logic [4:0]       WriteReg_mem,
  output logic [31:0]      Instruction_id,
  output logic [31:0]      PC_id,
  output logic [31:0]      NextPC_id,
  output logic             valid_id,
  output logic             PC_IFWrite,
  output logic             Bubble_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0]      instr_reg;
  logic [31:0]      pc_reg;
  logic [31:0]      npc_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       rs_used;
  logic       rt_used;
  logic       is_jr;
  logic       load_use;
  logic       jr_hazard;
  logic       stall;

  assign op    = instr_reg[31:26];
  assign rs    = instr_reg[25:21];
  assign rt    = instr_reg[20:16];
  assign funct = instr_reg[5:0];

  always_comb begin
    rs_used = 1'b1;
    if (op == 6'b000010 || op == 6'b000011)
      rs_used = 1'b0;
    // shifts by shamt read only rt
    else if (op == 6'b000000 &&
             (funct == 6'b000000 || funct == 6'b000010 || funct == 6'b000011))
      rs_used = 1'b0;
  end

  assign rt_used = (op == 6'b000000) || (op == 6'b000100) ||
                   (op == 6'b000101) || (op == 6'b101011);
  assign is_jr   = (op == 6'b000000) && (funct == 6'b001000);

  assign load_use = valid_reg && MemRead_ex && RegWrite_ex && (WriteReg_ex != 5'd0) &&
                    ((rs_used && rs == WriteReg_ex) || (rt_used && rt == WriteReg_ex));

  // JR resolves in ID, so it must also wait out a load sitting in MEM
  assign jr_hazard = valid_reg && is_jr && (rs != 5'd0) &&
                     ((RegWrite_ex && WriteReg_ex == rs) ||
                      (MemRead_mem && WriteReg_mem == rs));

  assign stall      = (load_use || jr_hazard) && !Flush;
  assign PC_IFWrite = ~stall;
  assign Bubble_ex  = stall | Flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_reg <= '0;
      pc_reg    <= '0;
      npc_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (Flush) begin
      instr_reg <= '0;
      pc_reg    <= PC;
      npc_reg   <= NextPC_if;
      valid_reg <= 1'b0;
    end else if (!stall) begin
      instr_reg <= Instruction_if;
      pc_reg    <= PC;
      npc_reg   <= NextPC_if;
      valid_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall && stall_cnt_reg != {CNT_W{1'b1}})
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (Flush && flush_cnt_reg != {CNT_W{1'b1}})
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign Instruction_id = instr_reg;
  assign PC_id          = pc_reg;
  assign NextPC_id      = npc_reg;
  assign valid_id       = valid_reg;
  assign stall_cnt      = stall_cnt_reg;
  assign flush_cnt      = flush_cnt_reg;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed, table-driven bench for if_id_stage (CNT_W = 4 so saturation is reachable).
module tb_if_id_stage;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [31:0]   Instruction_if, PC, NextPC_if;
  logic          Flush, MemRead_ex, RegWrite_ex, MemRead_mem;
  logic [4:0]    WriteReg_ex, WriteReg_mem;
  logic [31:0]   Instruction_id, PC_id, NextPC_id;
  logic          valid_id, PC_IFWrite, Bubble_ex;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  if_id_stage #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Instruction_if(Instruction_if), .PC(PC), .NextPC_if(NextPC_if),
    .Flush(Flush), .MemRead_ex(MemRead_ex), .RegWrite_ex(RegWrite_ex),
    .WriteReg_ex(WriteReg_ex), .MemRead_mem(MemRead_mem), .WriteReg_mem(WriteReg_mem),
    .Instruction_id(Instruction_id), .PC_id(PC_id), .NextPC_id(NextPC_id),
    .valid_id(valid_id), .PC_IFWrite(PC_IFWrite), .Bubble_ex(Bubble_ex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        fl;
    logic        mr_ex;
    logic        rw_ex;
    logic [4:0]  wr_ex;
    logic        mr_mem;
    logic [4:0]  wr_mem;
    logic        e_ifw;
    logic        e_bub;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic        e_valid;
    logic [3:0]  e_s;
    logic [3:0]  e_f;
  } vec_t;

  localparam logic [31:0] A  = 32'h00430820; // add $1,$2,$3
  localparam logic [31:0] B  = 32'h00A62020; // add $4,$5,$6
  localparam logic [31:0] C  = 32'h010A4820; // add $9,$8,$10
  localparam logic [31:0] D  = 32'h00223820; // add $7,$1,$2
  localparam logic [31:0] R0 = 32'h000A4820; // add $9,$0,$10
  localparam logic [31:0] J  = 32'h03E00008; // jr $31
  localparam logic [31:0] JJ = 32'h09000000; // j with rs field = 8

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] np,
                       input logic fl, input logic mre, input logic rwe, input logic [4:0] wre,
                       input logic mrm, input logic [4:0] wrm);
    Instruction_if = i; PC = p; NextPC_if = np; Flush = fl;
    MemRead_ex = mre; RegWrite_ex = rwe; WriteReg_ex = wre;
    MemRead_mem = mrm; WriteReg_mem = wrm;
  endtask

  initial begin
    vecs[0]  = '{A, 0, 4,   0,0,0,0, 0,0,   1,0, A, 0, 4,  1,0,0};
    vecs[1]  = '{B, 4, 8,   0,0,0,0, 0,0,   1,0, B, 4, 8,  1,0,0};
    vecs[2]  = '{C, 8, 12,  0,0,0,0, 0,0,   1,0, C, 8, 12, 1,0,0};
    vecs[3]  = '{D, 12,16,  0,1,1,8, 0,0,   0,1, C, 8, 12, 1,1,0};
    vecs[4]  = '{D, 12,16,  0,0,0,0, 0,0,   1,0, D, 12,16, 1,1,0};
    vecs[5]  = '{R0,16,20,  0,0,0,0, 0,0,   1,0, R0,16,20, 1,1,0};
    vecs[6]  = '{A, 20,24,  0,1,1,0, 0,0,   1,0, A, 20,24, 1,1,0};
    vecs[7]  = '{J, 24,28,  0,1,1,3, 0,0,   0,1, A, 20,24, 1,2,0};
    vecs[8]  = '{J, 24,28,  0,0,0,0, 0,0,   1,0, J, 24,28, 1,2,0};
    vecs[9]  = '{B, 28,32,  0,1,1,31,0,0,   0,1, J, 24,28, 1,3,0};
    vecs[10] = '{B, 28,32,  0,0,0,0, 1,31,  0,1, J, 24,28, 1,4,0};
    vecs[11] = '{B, 28,32,  0,0,0,0, 0,0,   1,0, B, 28,32, 1,4,0};
    vecs[12] = '{J, 32,36,  0,0,0,0, 0,0,   1,0, J, 32,36, 1,4,0};
    vecs[13] = '{B, 36,40,  0,0,1,31,0,0,   0,1, J, 32,36, 1,5,0};
    vecs[14] = '{B, 36,40,  0,0,0,0, 0,31,  1,0, B, 36,40, 1,5,0};
    vecs[15] = '{D, 40,44,  1,1,1,5, 0,0,   1,1, 0, 40,44, 0,5,1};
    vecs[16] = '{D, 44,48,  1,0,0,0, 0,0,   1,1, 0, 44,48, 0,5,2};
    vecs[17] = '{D, 48,52,  0,0,0,0, 0,0,   1,0, D, 48,52, 1,5,2};
    vecs[18] = '{JJ,52,56,  0,0,0,0, 0,0,   1,0, JJ,52,56, 1,5,2};
    vecs[19] = '{D, 56,60,  0,1,1,8, 0,0,   1,0, D, 56,60, 1,5,2};

    reset = 1'b0;
    drive(32'hDEADBEEF, 32'h1000, 32'h1004, 0, 1, 1, 8, 1, 31);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", Instruction_id, 0);
    chk("rst_pc", PC_id, 0);
    chk("rst_npc", NextPC_id, 0);
    chk("rst_valid", {31'd0, valid_id}, 0);
    chk("rst_ifw", {31'd0, PC_IFWrite}, 1);
    chk("rst_bub", {31'd0, Bubble_ex}, 0);
    chk("rst_scnt", {28'd0, stall_cnt}, 0);
    chk("rst_fcnt", {28'd0, flush_cnt}, 0);

    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].npc, vecs[i].fl, vecs[i].mr_ex,
            vecs[i].rw_ex, vecs[i].wr_ex, vecs[i].mr_mem, vecs[i].wr_mem);
      #1;
      chk($sformatf("v%0d_ifw", i), {31'd0, PC_IFWrite}, {31'd0, vecs[i].e_ifw});
      chk($sformatf("v%0d_bub", i), {31'd0, Bubble_ex}, {31'd0, vecs[i].e_bub});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_instr", i), Instruction_id, vecs[i].e_instr);
      chk($sformatf("v%0d_pc", i), PC_id, vecs[i].e_pc);
      chk($sformatf("v%0d_npc", i), NextPC_id, vecs[i].e_npc);
      chk($sformatf("v%0d_valid", i), {31'd0, valid_id}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_scnt", i), {28'd0, stall_cnt}, {28'd0, vecs[i].e_s});
      chk($sformatf("v%0d_fcnt", i), {28'd0, flush_cnt}, {28'd0, vecs[i].e_f});
      @(negedge clk);
    end

    // Saturation: flush_cnt starts at 2, 12 flushes reach 14, 8 more must stop at 15
    drive(D, 32'h80, 32'h84, 1, 0, 0, 0, 0, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("sat_fcnt14", {28'd0, flush_cnt}, 14);
    repeat (8) @(posedge clk);
    #1;
    chk("sat_fcnt15", {28'd0, flush_cnt}, 15);
    chk("sat_valid", {31'd0, valid_id}, 0);
    chk("sat_scnt", {28'd0, stall_cnt}, 5);

    // Async reset while stalled
    @(negedge clk);
    drive(C, 32'h100, 32'h104, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(D, 32'h104, 32'h108, 0, 1, 1, 8, 0, 0);
    #1;
    chk("mid_ifw", {31'd0, PC_IFWrite}, 0);
    chk("mid_bub", {31'd0, Bubble_ex}, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_instr", Instruction_id, 0);
    chk("arst_pc", PC_id, 0);
    chk("arst_npc", NextPC_id, 0);
    chk("arst_valid", {31'd0, valid_id}, 0);
    chk("arst_ifw", {31'd0, PC_IFWrite}, 1);
    chk("arst_bub", {31'd0, Bubble_ex}, 0);
    chk("arst_scnt", {28'd0, stall_cnt}, 0);
    chk("arst_fcnt", {28'd0, flush_cnt}, 0);
    @(posedge clk);
    #1;
    chk("arst_hold_instr", Instruction_id, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(C, 32'h200, 32'h204, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("post_instr", Instruction_id, C);
    chk("post_pc", PC_id, 32'h200);
    chk("post_valid", {31'd0, valid_id}, 1);
    chk("post_scnt", {28'd0, stall_cnt}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
